// File: rtl/debounce_pkg.sv
// Shared types and constants for the shared-timer switch debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_DELAY_CYCLES = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned rem;
        width = 0;
        rem   = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            width++;
            rem = rem >> 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/shared_delay_timer.sv
// Window timer shared by all debounce channels; Timeout flags the last count.
module shared_delay_timer
    import debounce_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = DEFAULT_DELAY_CYCLES
) (
    input  logic CLOCK,
    input  logic Reset,
    input  logic Clear,
    output logic Timeout
);

    localparam int unsigned CNT_W = clog2(DELAY_CYCLES);

    logic [CNT_W-1:0] count;

    assign Timeout = (count == CNT_W'(DELAY_CYCLES - 1));

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (Clear || Timeout) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/shared_debounce_scheduler.sv
// Debounces N_INPUTS switches with one shared timer granted round-robin.
// Optional DEBOUNCE_EARLY_ABORT_EN: release the timer as soon as the granted input bounces back.
module shared_debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int unsigned N_INPUTS     = 4,
    parameter int unsigned DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
    parameter int unsigned IDX_W        = $clog2(N_INPUTS)
) (
    input  logic                CLOCK,
    input  logic                Reset,
    input  logic [N_INPUTS-1:0] RawInputs,
    output logic [N_INPUTS-1:0] DebouncedOutputs,
    output logic [N_INPUTS-1:0] RisePulse,
    output logic [N_INPUTS-1:0] FallPulse,
    output logic                Busy,
    output logic [IDX_W-1:0]    GrantIndex
);

    state_t              state;
    logic [N_INPUTS-1:0] syncMeta;
    logic [N_INPUTS-1:0] syncLevel;
    logic [N_INPUTS-1:0] req;
    logic [IDX_W-1:0]    rrPtr;
    logic [IDX_W-1:0]    nextPtr;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    candidate;
    logic                anyReq;
    logic                timerClear;
    logic                timeout;

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            syncMeta  <= '0;
            syncLevel <= '0;
        end else begin
            syncMeta  <= RawInputs;
            syncLevel <= syncMeta;
        end
    end

    assign req        = syncLevel ^ DebouncedOutputs;
    assign Busy       = (state != IDLE);
    assign timerClear = (state != WAIT);
    assign nextPtr    = (32'(GrantIndex) == N_INPUTS - 1) ? '0 : GrantIndex + 1'b1;

    // First pending request found scanning upward from rrPtr with wrap-around.
    always_comb begin
        winner    = '0;
        anyReq    = 1'b0;
        candidate = '0;
        for (int unsigned k = 0; k < N_INPUTS; k++) begin
            candidate = IDX_W'((32'(rrPtr) + k) % N_INPUTS);
            if (!anyReq && req[candidate]) begin
                anyReq = 1'b1;
                winner = candidate;
            end
        end
    end

    shared_delay_timer #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) uTimer (
        .CLOCK  (CLOCK),
        .Reset  (Reset),
        .Clear  (timerClear),
        .Timeout(timeout)
    );

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state            <= IDLE;
            rrPtr            <= '0;
            GrantIndex       <= '0;
            DebouncedOutputs <= '0;
            RisePulse        <= '0;
            FallPulse        <= '0;
        end else begin
            RisePulse <= '0;
            FallPulse <= '0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        GrantIndex <= winner;
                        state      <= ARM;
                    end
                end
                ARM: begin
                    state <= WAIT;
                end
                WAIT: begin
`ifdef DEBOUNCE_EARLY_ABORT_EN
                    if (!req[GrantIndex]) begin
                        rrPtr <= nextPtr;
                        state <= IDLE;
                    end else if (timeout) begin
                        state <= CHECK;
                    end
`else
                    if (timeout) begin
                        state <= CHECK;
                    end
`endif
                end
                CHECK: begin
                    // A persisting mismatch means the new level equals the synchronized input.
                    if (req[GrantIndex]) begin
                        DebouncedOutputs[GrantIndex] <= syncLevel[GrantIndex];
                        if (syncLevel[GrantIndex]) begin
                            RisePulse[GrantIndex] <= 1'b1;
                        end else begin
                            FallPulse[GrantIndex] <= 1'b1;
                        end
                    end
                    rrPtr <= nextPtr;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
